// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word reads, queues responses with address/abort tag,
// and presents them to decode over valid/ready; a redirect flushes everything and refetches.
module instr_prefetch_buffer #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic [31:0] addr,
  output logic [1:0]  trans,
  output logic        write,
  output logic        size,
  output logic [1:0]  prot,
  input  logic [31:0] rdata,
  input  logic        abort,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_abort,
  input  logic        instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_t;

  trans_t          trans_reg;
  logic [31:0]     addr_reg;
  logic [31:0]     next_addr_reg;
  logic [31:0]     resp_addr_reg;
  logic            resp_pending_reg;
  logic            discard_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;

  logic [31:0]     data_mem  [DEPTH];
  logic [31:0]     addr_mem  [DEPTH];
  logic            abort_mem [DEPTH];

  logic            req_active;
  logic            push;
  logic            pop;
  logic [1:0]      inflight;
  logic [CW:0]     credit_used;
  logic            issue;

  assign req_active = (trans_reg != TRANS_IDLE);
  assign push       = resp_pending_reg & ~discard_reg;
  assign pop        = instr_valid & instr_ready;

  // Credit is reserved at issue: the request on the bus and the response
  // arriving now both count against FIFO space, so no response is ever dropped.
  assign inflight    = {1'b0, req_active} + {1'b0, push};
  assign credit_used = {1'b0, count_reg} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue       = ~flush & (credit_used < DEPTH_C);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      trans_reg        <= TRANS_IDLE;
      addr_reg         <= RESET_VECTOR;
      next_addr_reg    <= RESET_VECTOR;
      resp_addr_reg    <= RESET_VECTOR;
      resp_pending_reg <= 1'b0;
      discard_reg      <= 1'b0;
      count_reg        <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
    end else begin
      resp_pending_reg <= req_active;
      resp_addr_reg    <= addr_reg;
      if (flush) begin
        trans_reg     <= TRANS_NONSEQ;
        addr_reg      <= flush_addr;
        next_addr_reg <= flush_addr + 32'd1;
        // The request on the bus now returns next cycle and must not land.
        discard_reg   <= req_active;
        count_reg     <= '0;
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
      end else begin
        discard_reg <= 1'b0;
        if (issue) begin
          trans_reg     <= req_active ? TRANS_SEQ : TRANS_NONSEQ;
          addr_reg      <= next_addr_reg;
          next_addr_reg <= next_addr_reg + 32'd1;
        end else begin
          trans_reg <= TRANS_IDLE;
        end
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_mem[wr_ptr_reg]  <= rdata;
      addr_mem[wr_ptr_reg]  <= resp_addr_reg;
      abort_mem[wr_ptr_reg] <= abort;
    end
  end

  assign addr        = addr_reg;
  assign trans       = trans_reg;
  assign write       = 1'b0;
  assign size        = 1'b1;
  assign prot        = 2'b10;
  assign instr_valid = (count_reg != '0);
  assign instr       = data_mem[rd_ptr_reg];
  assign instr_addr  = addr_mem[rd_ptr_reg];
  assign instr_abort = abort_mem[rd_ptr_reg];

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: a one-cycle-latency memory model answers
// requests, and each step checks bus requests and presented instructions.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        write;
  logic        size;
  logic [1:0]  prot;
  logic [31:0] rdata;
  logic        abort;
  logic        flush;
  logic [31:0] flush_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_abort;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ABORT_ADDR = 32'd2;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .addr        (addr),
    .trans       (trans),
    .write       (write),
    .size        (size),
    .prot        (prot),
    .rdata       (rdata),
    .abort       (abort),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_abort (instr_abort),
    .instr_ready (instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: samples the request at the clock edge, returns data the next cycle.
  always @(posedge clk) begin
    if (trans != 2'b00) begin
      rdata <= mem_word(addr);
      abort <= (addr == ABORT_ADDR);
    end else begin
      rdata <= 32'hDEAD_BEEF;
      abort <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic exp_req(input string tag, input logic [1:0] t, input logic [31:0] a);
    chk({tag, "_trans"}, {30'd0, trans}, {30'd0, t});
    if (t != 2'b00) chk({tag, "_addr"}, addr, a);
  endtask

  task automatic exp_instr(input string tag, input logic [31:0] a, input logic ab);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_iaddr"}, instr_addr, a);
    chk({tag, "_instr"}, instr, mem_word(a));
    chk({tag, "_iabort"}, {31'd0, instr_abort}, {31'd0, ab});
  endtask

  task automatic exp_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    n_reset     = 1'b0;
    flush       = 1'b0;
    flush_addr  = 32'd0;
    instr_ready = 1'b1;
    repeat (2) step();

    // Reset state and tied-off controls
    exp_req("rst", 2'b00, 32'd0);
    chk("rst_addr", addr, 32'd0);
    exp_empty("rst");
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_size", {31'd0, size}, 32'd1);
    chk("rst_prot", {30'd0, prot}, 32'd2);

    // Streaming from reset with decode always ready; addr 2 returns abort
    n_reset = 1'b1;
    step(); exp_req("t1c1", 2'b10, 32'd0); exp_empty("t1c1");
    step(); exp_req("t1c2", 2'b11, 32'd1); exp_empty("t1c2");
    step(); exp_req("t1c3", 2'b11, 32'd2); exp_instr("t1c3", 32'd0, 1'b0);
    step(); exp_req("t1c4", 2'b11, 32'd3); exp_instr("t1c4", 32'd1, 1'b0);
    step(); exp_req("t1c5", 2'b11, 32'd4); exp_instr("t1c5", 32'd2, 1'b1);
    step(); exp_req("t1c6", 2'b11, 32'd5); exp_instr("t1c6", 32'd3, 1'b0);

    // Decode stalled from reset: exactly DEPTH requests, then idle while full
    n_reset = 1'b0; instr_ready = 1'b0;
    step(); n_reset = 1'b1;
    step(); exp_req("t2c1", 2'b10, 32'd0);
    step(); exp_req("t2c2", 2'b11, 32'd1);
    step(); exp_req("t2c3", 2'b11, 32'd2); exp_instr("t2c3", 32'd0, 1'b0);
    step(); exp_req("t2c4", 2'b11, 32'd3);
    step(); exp_req("t2c5", 2'b00, 32'd0);
    step(); exp_req("t2c6", 2'b00, 32'd0); exp_instr("t2c6", 32'd0, 1'b0);
    step(); exp_req("t2c7", 2'b00, 32'd0); exp_instr("t2c7", 32'd0, 1'b0);
    instr_ready = 1'b1;
    step(); exp_req("t2r1", 2'b10, 32'd4); exp_instr("t2r1", 32'd1, 1'b0);
    step(); exp_req("t2r2", 2'b11, 32'd5); exp_instr("t2r2", 32'd2, 1'b1);
    step(); exp_req("t2r3", 2'b11, 32'd6); exp_instr("t2r3", 32'd3, 1'b0);
    step(); exp_req("t2r4", 2'b11, 32'd7); exp_instr("t2r4", 32'd4, 1'b0);

    // Redirect while addr 7 is on the bus: its word must never appear
    flush = 1'b1; flush_addr = 32'h40;
    step(); exp_req("t3c1", 2'b10, 32'h40); exp_empty("t3c1");
    flush = 1'b0;
    step(); exp_req("t3c2", 2'b11, 32'h41); exp_empty("t3c2");
    step(); exp_req("t3c3", 2'b11, 32'h42); exp_instr("t3c3", 32'h40, 1'b0);
    step(); exp_instr("t3c4", 32'h41, 1'b0);

    // Back-to-back redirects: the latest target wins
    flush = 1'b1; flush_addr = 32'h100;
    step(); exp_req("fxc1", 2'b10, 32'h100); exp_empty("fxc1");
    flush_addr = 32'h200;
    step(); exp_req("fxc2", 2'b10, 32'h200); exp_empty("fxc2");
    flush = 1'b0;
    step(); exp_req("fxc3", 2'b11, 32'h201); exp_empty("fxc3");
    step(); exp_instr("fxc4", 32'h200, 1'b0);

    // Address wrap stays sequential
    flush = 1'b1; flush_addr = 32'hFFFF_FFFE;
    step(); exp_req("t5c1", 2'b10, 32'hFFFF_FFFE);
    flush = 1'b0;
    step(); exp_req("t5c2", 2'b11, 32'hFFFF_FFFF);
    step(); exp_req("t5c3", 2'b11, 32'h0000_0000); exp_instr("t5c3", 32'hFFFF_FFFE, 1'b0);
    step(); exp_req("t5c4", 2'b11, 32'h0000_0001); exp_instr("t5c4", 32'hFFFF_FFFF, 1'b0);
    step(); exp_instr("t5c5", 32'd0, 1'b0);
    step(); exp_instr("t5c6", 32'd1, 1'b0);
    step(); exp_instr("t5c7", 32'd2, 1'b1);

    // Asynchronous reset with three words queued and a request on the bus
    n_reset = 1'b0; instr_ready = 1'b0;
    step(); n_reset = 1'b1;
    repeat (7) step();
    instr_ready = 1'b1;
    step(); exp_req("t6pre", 2'b10, 32'd4); exp_instr("t6pre", 32'd1, 1'b0);
    #2 n_reset = 1'b0;
    #1;
    exp_req("t6rst", 2'b00, 32'd0);
    chk("t6rst_addr", addr, 32'd0);
    exp_empty("t6rst");
    @(negedge clk); n_reset = 1'b1;
    step(); exp_req("t6c1", 2'b10, 32'd0); exp_empty("t6c1");
    step(); exp_req("t6c2", 2'b11, 32'd1);
    step(); exp_instr("t6c3", 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Fetch front end between the memory controller and the processor's fetch/decode pipeline.
- Issues sequential word-address instruction reads and captures the registered read data one cycle later.
- Queues fetched words with their address and abort tag in a small FIFO, and hands them to decode over a valid/ready handshake.
- Flushes all queued and in-flight fetches on a branch redirect and restarts fetching at the target.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2.
RESET_VECTOR, 32'h0000_0000, first fetch word address after reset.

Ports:
clk  input  1  clock, all state on rising edge.
n_reset  input  1  asynchronous active-low reset.
addr  output  32  fetch word address to memory controller (registered).
trans  output  2  00 idle, 10 non-sequential, 11 sequential (registered).
write  output  1  tied 0.
size  output  1  tied 1 (word).
prot  output  2  tied 2'b10 (privileged opcode fetch).
rdata  input  32  memory read data, valid the cycle after a request.
abort  input  1  fetch abort, qualified with rdata.
flush  input  1  redirect: discard everything, refetch from flush_addr.
flush_addr  input  32  redirect target word address.
instr_valid  output  1  FIFO head valid.
instr  output  32  FIFO head instruction word.
instr_addr  output  32  word address of head.
instr_abort  output  1  head fetch aborted.
instr_ready  input  1  decode accepts head this cycle.

Behaviour:
- Reset, asynchronous, while n_reset=0:
  - addr = RESET_VECTOR, trans = 00, instr_valid = 0.
  - FIFO count = 0, read and write pointers = 0, inflight = 0, discard = 0, next fetch address = RESET_VECTOR.
  - Reset mid-operation drops every queued and in-flight word. No partial state survives.
- Request timing:
  - A request is a cycle with trans != 00 on the outputs.
  - The memory samples the request at the end of that cycle. rdata/abort are valid during the next cycle.
  - The block writes {rdata, abort, request addr} into the FIFO at the end of that next cycle, and sets inflight = 0.
  - instr_valid rises the cycle after the write. Minimum fetch-to-valid latency is 2 cycles.
- Issue rule, evaluated each edge:
  - Issue when count + inflight - (instr_valid & instr_ready) < DEPTH and flush = 0.
  - On issue: addr <= next address, next address <= next address + 1. Wrap 32'hFFFF_FFFF -> 0 with no special handling; trans stays 11 across the wrap.
  - Otherwise trans <= 00 and addr holds its value.
- trans encoding:
  - 10 for the first request after reset, after a flush, or after any idle (00) cycle.
  - 11 for a request that directly follows a request.
- Back-to-back streaming: one request per cycle while the FIFO has room. Steady-state throughput is 1 word/cycle when decode pops every cycle.
- Pop:
  - When instr_valid & instr_ready, advance the read pointer and decrement count.
  - Simultaneous push and pop leaves count unchanged.
- Full (count = DEPTH):
  - instr_valid = 1; the issue rule prevents new requests.
  - An arriving response is never dropped, because credit was reserved at issue time.
- Empty: instr_valid = 0. instr, instr_addr and instr_abort are don't-care.
- Flush, highest priority:
  - On the edge with flush = 1: count <= 0, pointers <= 0, addr <= flush_addr, trans <= 10, next address <= flush_addr + 1.
  - If a request is outstanding, or is being presented in the flush cycle, set discard so its response is not written. Discard clears when the response cycle passes.
  - A pop coinciding with flush is ignored; the FIFO is emptied anyway.
  - A flush on consecutive cycles restarts from the latest flush_addr each time.
- Abort:
  - Stored with the word and presented as instr_abort.
  - Fetching continues; decode decides how to act on it.
- Outputs instr, instr_addr and instr_abort are driven from FIFO storage at the read pointer. No extra register stage.

Test Plan:
1. Reset release with mem[0..3] = A0..A3, instr_ready = 1 -> cycle 1: trans = 10, addr = 0; cycle 2: trans = 11, addr = 1; cycle 3: instr_valid = 1, instr = A0, instr_addr = 0; then A1, A2, A3 on consecutive cycles.
2. instr_ready = 0 from reset, DEPTH = 4 -> exactly 4 requests (addr 0..3), then trans = 00; count = 4. Raise instr_ready -> next request is trans = 10, addr = 4, and the words come out in order 0..4 with none lost.
3. Streaming, then flush with flush_addr = 32'h40 while a request to addr 7 is in flight -> next cycle trans = 10, addr = 40h; the word from addr 7 is never presented; the first instr_valid shows instr_addr = 40h.
4. abort = 1 on the response for addr 2 -> instr_addr = 2 is presented with instr_abort = 1; addr 3 follows with instr_abort = 0 and no gap in fetching.
5. flush_addr = 32'hFFFF_FFFE -> requests FFFF_FFFE (10), FFFF_FFFF (11), 0 (11), 1 (11).
6. Assert n_reset = 0 mid-stream with count = 3 -> instr_valid and trans drop to 0 immediately (asynchronously). After release, fetching restarts at RESET_VECTOR with trans = 10.
